// File: rtl/reg_file_copier_if.sv
// Method-style port bundle between the copier engine and its environment
// (control rule, source and destination register files).
interface reg_file_copier_if #(
    parameter int unsigned size  = 1,
    parameter int unsigned width = 1
);
    // Job control
    logic               EN_start;
    logic [size-1:0]    start_src;
    logic [size-1:0]    start_dst;
    logic [size:0]      start_len;
    logic               start_fill;
    logic [width-1:0]   start_val;
    logic               RDY_start;

    // Source read call (sub)
    logic [size-1:0]    rd_x;
    logic               EN_rd;
    logic               RDY_rd;
    logic [width-1:0]   rd_data;

    // Destination write call (upd)
    logic [size-1:0]    wr_x;
    logic [width-1:0]   wr_y;
    logic               EN_wr;
    logic               RDY_wr;

    // Completion
    logic [size:0]      result;
    logic               RDY_result;
    logic               EN_result;

    // Environment side
    modport master (
        output EN_start, start_src, start_dst, start_len, start_fill, start_val,
        output RDY_rd, rd_data, RDY_wr, EN_result,
        input  RDY_start, rd_x, EN_rd, wr_x, wr_y, EN_wr, result, RDY_result
    );

    // Copier engine side
    modport slave (
        input  EN_start, start_src, start_dst, start_len, start_fill, start_val,
        input  RDY_rd, rd_data, RDY_wr, EN_result,
        output RDY_start, rd_x, EN_rd, wr_x, wr_y, EN_wr, result, RDY_result
    );
endinterface

// File: rtl/reg_file_copier.sv
// Block copy / constant fill engine driving sub-style reads into a source
// register file and upd-style writes into a destination register file.
// One read stage register sits between the two ports; one word per cycle.
module reg_file_copier #(
    parameter int unsigned size  = 1,
    parameter int unsigned width = 1
) (
    input  logic               CLK,
    input  logic               RST,
    reg_file_copier_if.slave   io_bus
);
    localparam int unsigned AW = size;
    localparam int unsigned CW = size + 1;
    localparam int unsigned DW = width;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;

    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [CW-1:0] r_len;
    logic          r_fill;
    logic [DW-1:0] r_val;
    logic [CW-1:0] r_rdcnt;
    logic [CW-1:0] r_wrcnt;
    logic [CW-1:0] r_result;
    logic          r_stage_vld;
    logic [DW-1:0] r_stage_data;

    logic          w_en_rd;
    logic          w_en_wr;
    logic          w_rd_take;
    logic          w_wr_take;
    logic          w_last_wr;
    logic [AW-1:0] w_rd_x;
    logic [AW-1:0] w_wr_x;
    logic [DW-1:0] w_wr_y;

    // Call decode from state only, take decode, and next-state logic
    always_comb begin
        w_en_rd     = 1'b0;
        w_en_wr     = 1'b0;
        w_rd_x      = AW'(r_src + r_rdcnt[AW-1:0]);
        w_wr_x      = AW'(r_dst + r_wrcnt[AW-1:0]);
        w_wr_y      = r_fill ? r_val : r_stage_data;
        w_state_nxt = r_state;

        if (r_state == S_RUN) begin
            w_en_rd = !r_fill && (r_rdcnt < r_len);
            w_en_wr = r_fill ? (r_wrcnt < r_len) : r_stage_vld;
        end

        w_wr_take = w_en_wr && io_bus.RDY_wr;
        // A full stage can only refill when its word leaves this cycle
        w_rd_take = w_en_rd && io_bus.RDY_rd && (!r_stage_vld || w_wr_take);
        w_last_wr = w_wr_take && (CW'(r_wrcnt + 1'b1) == r_len);

        case (r_state)
            S_IDLE: if (io_bus.EN_start)
                        w_state_nxt = (io_bus.start_len == '0) ? S_DONE : S_RUN;
            S_RUN:  if (w_last_wr)
                        w_state_nxt = S_DONE;
            S_DONE: if (io_bus.EN_result)
                        w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Job parameters, counters, stage register and result
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_fill       <= 1'b0;
            r_val        <= '0;
            r_rdcnt      <= '0;
            r_wrcnt      <= '0;
            r_result     <= '0;
            r_stage_vld  <= 1'b0;
            r_stage_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.EN_start) begin
                        r_src       <= io_bus.start_src;
                        r_dst       <= io_bus.start_dst;
                        r_len       <= io_bus.start_len;
                        r_fill      <= io_bus.start_fill;
                        r_val       <= io_bus.start_val;
                        r_rdcnt     <= '0;
                        r_wrcnt     <= '0;
                        r_result    <= '0;
                        r_stage_vld <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_rd_take) begin
                        r_stage_data <= io_bus.rd_data;
                        r_rdcnt      <= CW'(r_rdcnt + 1'b1);
                    end
                    if (w_wr_take)
                        r_wrcnt <= CW'(r_wrcnt + 1'b1);
                    if (w_rd_take)
                        r_stage_vld <= 1'b1;
                    else if (w_wr_take)
                        r_stage_vld <= 1'b0;
                    if (w_last_wr)
                        r_result <= CW'(r_wrcnt + 1'b1);
                end
                default: ;
            endcase
        end
    end

    assign io_bus.RDY_start  = (r_state == S_IDLE);
    assign io_bus.RDY_result = (r_state == S_DONE);
    assign io_bus.result     = r_result;
    assign io_bus.EN_rd      = w_en_rd;
    assign io_bus.rd_x       = w_rd_x;
    assign io_bus.EN_wr      = w_en_wr;
    assign io_bus.wr_x       = w_wr_x;
    assign io_bus.wr_y       = w_wr_y;
endmodule

// File: tb/tb_reg_file_copier.sv
// Directed bench for reg_file_copier: a size=4 instance with source and
// destination register-file models (optionally aliased), and a size=3
// instance for wrap-around fill.
module tb_reg_file_copier;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_copier_if #(.size(4), .width(8)) a_if ();
    reg_file_copier_if #(.size(3), .width(8)) b_if ();

    reg_file_copier #(.size(4), .width(8)) dut_a (.CLK(CLK), .RST(RST), .io_bus(a_if));
    reg_file_copier #(.size(3), .width(8)) dut_b (.CLK(CLK), .RST(RST), .io_bus(b_if));

    // Register-file models; preload goes through the same clocked block
    logic [7:0] a_src [16];
    logic [7:0] a_dst [16];
    int         a_hits[16];
    logic [7:0] a_ld_src[16];
    logic [7:0] a_ld_dst[16];
    logic       a_ld = 1'b0;
    logic       a_alias = 1'b0;
    logic [7:0] b_dst [8];
    int         b_hits[8];
    logic       b_ld = 1'b0;

    assign a_if.rd_data = a_alias ? a_dst[a_if.rd_x] : a_src[a_if.rd_x];
    assign b_if.rd_data = 8'h3C;

    always @(posedge CLK) begin
        if (a_ld) begin
            for (int i = 0; i < 16; i++) begin
                a_src[i]  <= a_ld_src[i];
                a_dst[i]  <= a_ld_dst[i];
                a_hits[i] <= 0;
            end
        end else if (a_if.EN_wr === 1'b1 && a_if.RDY_wr === 1'b1) begin
            a_dst[a_if.wr_x]  <= a_if.wr_y;
            a_hits[a_if.wr_x] <= a_hits[a_if.wr_x] + 1;
        end
    end

    always @(posedge CLK) begin
        if (b_ld) begin
            for (int i = 0; i < 8; i++) begin
                b_dst[i]  <= 8'h00;
                b_hits[i] <= 0;
            end
        end else if (b_if.EN_wr === 1'b1 && b_if.RDY_wr === 1'b1) begin
            b_dst[b_if.wr_x]  <= b_if.wr_y;
            b_hits[b_if.wr_x] <= b_hits[b_if.wr_x] + 1;
        end
    end

    task automatic a_load();
        a_ld = 1'b1;
        @(posedge CLK); #1;
        a_ld = 1'b0;
        @(negedge CLK);
    endtask

    task automatic a_start(input logic [3:0] src, input logic [3:0] dst,
                           input logic [4:0] len, input logic fill, input logic [7:0] val);
        a_if.EN_start = 1'b1; a_if.start_src = src; a_if.start_dst = dst;
        a_if.start_len = len; a_if.start_fill = fill; a_if.start_val = val;
        @(posedge CLK); #1;
        a_if.EN_start = 1'b0;
    endtask

    task automatic a_consume();
        a_if.EN_result = 1'b1;
        @(posedge CLK); #1;
        a_if.EN_result = 1'b0;
        @(negedge CLK);
    endtask

    task automatic b_start(input logic [2:0] dst, input logic [3:0] len, input logic [7:0] val);
        b_if.EN_start = 1'b1; b_if.start_src = 3'd0; b_if.start_dst = dst;
        b_if.start_len = len; b_if.start_fill = 1'b1; b_if.start_val = val;
        @(posedge CLK); #1;
        b_if.EN_start = 1'b0;
    endtask

    task automatic b_consume();
        b_if.EN_result = 1'b1;
        @(posedge CLK); #1;
        b_if.EN_result = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(negedge CLK); @(negedge CLK);
        n_checks++;
        if ({a_if.RDY_start, a_if.EN_rd, a_if.EN_wr, a_if.RDY_result} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_ctrl_a: got %b expected 1000",
                {a_if.RDY_start, a_if.EN_rd, a_if.EN_wr, a_if.RDY_result});
        end
        n_checks++;
        if (a_if.result !== 5'd0) begin
            n_fail++; $display("FAIL reset_result_a: got %0d expected 0", a_if.result);
        end
        n_checks++;
        if ({b_if.RDY_start, b_if.EN_rd, b_if.EN_wr, b_if.RDY_result} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_ctrl_b: got %b expected 1000",
                {b_if.RDY_start, b_if.EN_rd, b_if.EN_wr, b_if.RDY_result});
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_copy();
        logic erd, ewr, eres;
        for (int i = 0; i < 16; i++) begin a_ld_src[i] = 8'(i + 16); a_ld_dst[i] = 8'h00; end
        a_load();
        a_start(4'd2, 4'd8, 5'd3, 1'b0, 8'h00);
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            erd = (c <= 3); ewr = (c >= 2 && c <= 4); eres = (c == 5);
            n_checks++;
            if ({a_if.EN_rd, a_if.EN_wr, a_if.RDY_result} !== {erd, ewr, eres}) begin
                n_fail++; $display("FAIL copy_ctrl c=%0d: got %b expected %b", c,
                    {a_if.EN_rd, a_if.EN_wr, a_if.RDY_result}, {erd, ewr, eres});
            end
            if (erd) begin
                n_checks++;
                if (a_if.rd_x !== 4'(2 + c - 1)) begin
                    n_fail++; $display("FAIL copy_rd_x c=%0d: got %0d expected %0d", c, a_if.rd_x, 2 + c - 1);
                end
            end
            if (ewr) begin
                n_checks++;
                if ({a_if.wr_x, a_if.wr_y} !== {4'(8 + c - 2), 8'(8'h12 + c - 2)}) begin
                    n_fail++; $display("FAIL copy_wr c=%0d: got %0d/%h expected %0d/%h", c,
                        a_if.wr_x, a_if.wr_y, 8 + c - 2, 8'h12 + c - 2);
                end
            end
            if (eres) begin
                n_checks++;
                if (a_if.result !== 5'd3) begin
                    n_fail++; $display("FAIL copy_result: got %0d expected 3", a_if.result);
                end
            end
        end
        a_consume();
        n_checks++;
        if ({a_if.RDY_start, a_if.RDY_result} !== 2'b10) begin
            n_fail++; $display("FAIL copy_idle: got %b expected 10", {a_if.RDY_start, a_if.RDY_result});
        end
        for (int i = 8; i <= 10; i++) begin
            n_checks++;
            if (a_dst[i] !== 8'(8'h12 + i - 8) || a_hits[i] !== 1) begin
                n_fail++; $display("FAIL copy_mem[%0d]: got %h x%0d expected %h x1", i, a_dst[i], a_hits[i], 8'h12 + i - 8);
            end
        end
    endtask

    task automatic test_fill_wrap();
        logic [7:0] ev;
        int         eh;
        b_ld = 1'b1; @(posedge CLK); #1; b_ld = 1'b0; @(negedge CLK);
        b_start(3'd6, 4'd4, 8'hA5);
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            n_checks++;
            if ({b_if.EN_rd, b_if.EN_wr, b_if.RDY_result} !== {1'b0, c <= 4, c == 5}) begin
                n_fail++; $display("FAIL fill_ctrl c=%0d: got %b", c, {b_if.EN_rd, b_if.EN_wr, b_if.RDY_result});
            end
            if (c <= 4) begin
                n_checks++;
                if ({b_if.wr_x, b_if.wr_y} !== {3'(6 + c - 1), 8'hA5}) begin
                    n_fail++; $display("FAIL fill_wr c=%0d: got %0d/%h expected %0d/a5", c, b_if.wr_x, b_if.wr_y, 3'(6 + c - 1));
                end
            end else begin
                n_checks++;
                if (b_if.result !== 4'd4) begin
                    n_fail++; $display("FAIL fill_result: got %0d expected 4", b_if.result);
                end
            end
        end
        b_consume();
        for (int i = 0; i < 8; i++) begin
            ev = (i == 6 || i == 7 || i == 0 || i == 1) ? 8'hA5 : 8'h00;
            eh = (ev == 8'hA5) ? 1 : 0;
            n_checks++;
            if (b_dst[i] !== ev || b_hits[i] !== eh) begin
                n_fail++; $display("FAIL fill_mem[%0d]: got %h x%0d expected %h x%0d", i, b_dst[i], b_hits[i], ev, eh);
            end
        end
    endtask

    task automatic test_backpressure();
        logic       erd[9];
        logic       ewr[9];
        int         erx[9];
        int         ewx[9];
        logic [7:0] ewy[9];
        erd = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
        erx = '{0, 0, 1, 2, 2, 2, 3, 0, 0};
        ewr = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        ewx = '{0, 0, 4, 5, 5, 5, 6, 7, 0};
        ewy = '{8'h00, 8'h00, 8'h10, 8'h11, 8'h11, 8'h11, 8'h12, 8'h13, 8'h00};
        for (int i = 0; i < 16; i++) begin a_ld_src[i] = 8'(i + 16); a_ld_dst[i] = 8'h00; end
        a_load();
        a_start(4'd0, 4'd4, 5'd4, 1'b0, 8'h00);
        for (int c = 1; c <= 8; c++) begin
            @(negedge CLK);
            n_checks++;
            if ({a_if.EN_rd, a_if.EN_wr, a_if.RDY_result} !== {erd[c], ewr[c], c == 8}) begin
                n_fail++; $display("FAIL bp_ctrl c=%0d: got %b expected %b", c,
                    {a_if.EN_rd, a_if.EN_wr, a_if.RDY_result}, {erd[c], ewr[c], c == 8});
            end
            if (erd[c]) begin
                n_checks++;
                if (a_if.rd_x !== 4'(erx[c])) begin
                    n_fail++; $display("FAIL bp_rd_x c=%0d: got %0d expected %0d", c, a_if.rd_x, erx[c]);
                end
            end
            if (ewr[c]) begin
                n_checks++;
                if ({a_if.wr_x, a_if.wr_y} !== {4'(ewx[c]), ewy[c]}) begin
                    n_fail++; $display("FAIL bp_wr c=%0d: got %0d/%h expected %0d/%h", c, a_if.wr_x, a_if.wr_y, ewx[c], ewy[c]);
                end
            end
            a_if.RDY_wr = !(c == 3 || c == 4);
        end
        n_checks++;
        if (a_if.result !== 5'd4) begin
            n_fail++; $display("FAIL bp_result: got %0d expected 4", a_if.result);
        end
        a_if.RDY_wr = 1'b1;
        a_consume();
        for (int i = 4; i <= 7; i++) begin
            n_checks++;
            if (a_dst[i] !== 8'(i + 12) || a_hits[i] !== 1) begin
                n_fail++; $display("FAIL bp_mem[%0d]: got %h x%0d expected %h x1", i, a_dst[i], a_hits[i], i + 12);
            end
        end
    endtask

    task automatic test_len0();
        int total;
        a_start(4'd5, 4'd5, 5'd0, 1'b0, 8'h00);
        @(negedge CLK);
        n_checks++;
        if ({a_if.EN_rd, a_if.EN_wr, a_if.RDY_result, a_if.RDY_start} !== 4'b0010) begin
            n_fail++; $display("FAIL len0_ctrl: got %b expected 0010",
                {a_if.EN_rd, a_if.EN_wr, a_if.RDY_result, a_if.RDY_start});
        end
        n_checks++;
        if (a_if.result !== 5'd0) begin
            n_fail++; $display("FAIL len0_result: got %0d expected 0", a_if.result);
        end
        a_consume();
        total = 0;
        for (int i = 0; i < 16; i++) total += a_hits[i];
        n_checks++;
        if (total !== 4) begin
            n_fail++; $display("FAIL len0_writes: got %0d total writes expected 4", total);
        end
    endtask

    task automatic test_full_len();
        int done_c;
        for (int i = 0; i < 16; i++) begin a_ld_src[i] = 8'(i * 3 + 1); a_ld_dst[i] = 8'h00; end
        a_load();
        a_start(4'd0, 4'd0, 5'd16, 1'b0, 8'h00);
        done_c = 0;
        for (int c = 1; c <= 30 && done_c == 0; c++) begin
            @(negedge CLK);
            if (a_if.RDY_result === 1'b1) done_c = c;
            if (c == 5) begin
                a_if.EN_start = 1'b1; a_if.start_dst = 4'd3; a_if.start_len = 5'd1;
                a_if.start_fill = 1'b1; a_if.start_val = 8'hFF;
            end else begin
                a_if.EN_start = 1'b0;
            end
        end
        a_if.EN_start = 1'b0;
        n_checks++;
        if (done_c !== 18) begin
            n_fail++; $display("FAIL full_done_cycle: got %0d expected 18", done_c);
        end
        n_checks++;
        if (a_if.result !== 5'd16) begin
            n_fail++; $display("FAIL full_result: got %0d expected 16", a_if.result);
        end
        a_consume();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (a_dst[i] !== 8'(i * 3 + 1) || a_hits[i] !== 1) begin
                n_fail++; $display("FAIL full_mem[%0d]: got %h x%0d expected %h x1", i, a_dst[i], a_hits[i], 8'(i * 3 + 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) begin a_ld_src[i] = 8'(i + 16); a_ld_dst[i] = 8'h00; end
        a_load();
        a_start(4'd0, 4'd0, 5'd8, 1'b0, 8'h00);
        for (int c = 1; c <= 3; c++) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({a_if.EN_rd, a_if.EN_wr, a_if.RDY_result, a_if.RDY_start} !== 4'b0001) begin
            n_fail++; $display("FAIL rstmid_ctrl: got %b expected 0001",
                {a_if.EN_rd, a_if.EN_wr, a_if.RDY_result, a_if.RDY_start});
        end
        n_checks++;
        if (a_if.result !== 5'd0) begin
            n_fail++; $display("FAIL rstmid_result: got %0d expected 0", a_if.result);
        end
        RST = 1'b0;
        a_start(4'd4, 4'd12, 5'd2, 1'b0, 8'h00);
        for (int c = 1; c <= 4; c++) @(negedge CLK);
        n_checks++;
        if ({a_if.RDY_result, a_if.result} !== {1'b1, 5'd2}) begin
            n_fail++; $display("FAIL rstmid_rejob: got rdy=%b result=%0d expected rdy=1 result=2",
                a_if.RDY_result, a_if.result);
        end
        a_consume();
        n_checks++;
        if ({a_dst[12], a_dst[13]} !== {8'h14, 8'h15}) begin
            n_fail++; $display("FAIL rstmid_mem: got %h %h expected 14 15", a_dst[12], a_dst[13]);
        end
    endtask

    task automatic test_inplace();
        int done_c;
        for (int i = 0; i < 16; i++) begin a_ld_src[i] = 8'h00; a_ld_dst[i] = 8'(8'h40 + i); end
        a_load();
        a_alias = 1'b1;
        a_start(4'd1, 4'd0, 5'd5, 1'b0, 8'h00);
        done_c = 0;
        for (int c = 1; c <= 20 && done_c == 0; c++) begin
            @(negedge CLK);
            if (a_if.RDY_result === 1'b1) done_c = c;
        end
        n_checks++;
        if (done_c !== 7 || a_if.result !== 5'd5) begin
            n_fail++; $display("FAIL inplace_done: got cycle %0d result %0d expected cycle 7 result 5", done_c, a_if.result);
        end
        a_consume();
        for (int i = 0; i <= 5; i++) begin
            n_checks++;
            if (a_dst[i] !== 8'(8'h41 + ((i < 5) ? i : 4))) begin
                n_fail++; $display("FAIL inplace_mem[%0d]: got %h expected %h", i, a_dst[i], 8'(8'h41 + ((i < 5) ? i : 4)));
            end
        end
        a_alias = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        a_if.EN_start = 1'b0; a_if.start_src = '0; a_if.start_dst = '0; a_if.start_len = '0;
        a_if.start_fill = 1'b0; a_if.start_val = '0;
        a_if.RDY_rd = 1'b1; a_if.RDY_wr = 1'b1; a_if.EN_result = 1'b0;
        b_if.EN_start = 1'b0; b_if.start_src = '0; b_if.start_dst = '0; b_if.start_len = '0;
        b_if.start_fill = 1'b0; b_if.start_val = '0;
        b_if.RDY_rd = 1'b1; b_if.RDY_wr = 1'b1; b_if.EN_result = 1'b0;
        for (int i = 0; i < 16; i++) begin a_ld_src[i] = 8'h00; a_ld_dst[i] = 8'h00; end

        test_reset();
        test_copy();
        test_fill_wrap();
        test_backpressure();
        test_len0();
        test_full_len();
        test_reset_mid();
        test_inplace();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
